// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder slice.
package nibble_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

endpackage

// File: rtl/adder.sv
// Existing 4-bit ripple carry adder used as the per-nibble datapath.
module adder
  import nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] input1,
  input  logic [NIBBLE_W-1:0] input2,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry_out
);

  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = carry_in;

  // Full-adder chain, one stage per bit.
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]   = input1[i] ^ input2[i] ^ w_c[i];
    assign w_c[i+1] = (input1[i] & input2[i]) | (w_c[i] & (input1[i] ^ input2[i]));
  end

  assign carry_out = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide add/subtract computed one nibble per clock through a 4-bit adder.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_overflow
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

  nsa_state_t r_state;
  nsa_state_t w_state_nxt;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_carry;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_sum;
  logic                r_a_msb;
  logic                r_b_msb;
  logic                r_ovf;

  logic [WIDTH-1:0]    w_b_eff;
  logic                w_accept;
  logic                w_last;
  logic [NIBBLE_W-1:0] w_nib_sum;
  logic                w_nib_cout;

  assign w_b_eff  = in_sub ? ~in_b : in_b;
  assign w_accept = in_valid & (r_state == IDLE);
  assign w_last   = (r_state == RUN) & (r_cnt == LAST_CNT);

  adder u_adder (
    .input1    (r_a[NIBBLE_W-1:0]),
    .input2    (r_b[NIBBLE_W-1:0]),
    .carry_in  (r_carry),
    .sum       (w_nib_sum),
    .carry_out (w_nib_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: accept in IDLE, NIB nibble cycles in RUN, hold in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Operand shift registers, carry, counter and result assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= w_b_eff;
      r_carry <= in_sub ? 1'b1 : in_cin;
      r_cnt   <= '0;
      r_a_msb <= in_a[WIDTH-1];
      r_b_msb <= w_b_eff[WIDTH-1];
    end else if (r_state == RUN) begin
      r_a     <= r_a >> NIBBLE_W;
      r_b     <= r_b >> NIBBLE_W;
      r_sum   <= WIDTH'({w_nib_sum, r_sum} >> NIBBLE_W);
      r_carry <= w_nib_cout;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      // Top nibble's sum MSB is the result sign; compare against latched operand signs.
      if (w_last) begin
        r_ovf <= (r_a_msb == r_b_msb) & (w_nib_sum[NIBBLE_W-1] != r_a_msb);
      end
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == DONE);
  assign out_sum      = r_sum;
  assign out_cout     = r_carry;
  assign out_overflow = r_ovf;

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder/subtractor that slices two WIDTH-bit operands into 4-bit nibbles and feeds them, LSB nibble first, through the team's existing 4-bit ripple carry adder, one nibble per clock.
- The nibble carry is registered between cycles, and the result is assembled in a shift register.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area in datapaths wider than 4 bits.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. NIB = WIDTH/4 nibble cycles per operation.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept an operand bundle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in for add; ignored when in_sub=1
- in_sub  input  1  1 = compute A-B, 0 = compute A+B+cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  final carry out; for subtract, 1 = no borrow
- out_overflow  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst is asynchronous, active-high, and forces every register to its reset value immediately.
- Reset values:
  - State is IDLE, nibble counter 0, carry register 0, out_valid 0, out_sum 0, out_cout 0, out_overflow 0.
  - in_ready = 1 once rst deasserts.
- FSM states: IDLE, RUN, DONE. in_ready is 1 only in IDLE; out_valid is 1 only in DONE. Both are decoded directly from state registers (no combinational input-to-output paths).
- IDLE:
  - On an accept edge (in_valid & in_ready): latch A, and B_eff = in_sub ? ~in_b : in_b.
  - Set the carry register to in_sub ? 1 : in_cin, clear the counter, and go to RUN.
- RUN:
  - Each cycle, the adder receives nibble 0 of the A and B_eff shift registers plus the carry register.
  - At the edge, the sum nibble is shifted into the MSB end of the result register, A/B_eff shift right by 4, the carry register takes the adder carry_out, and the counter increments.
  - When the counter reaches NIB-1 and that edge completes, the state goes to DONE.
- Latency: out_valid rises exactly NIB cycles after the accept edge (4 for WIDTH=16).
- DONE:
  - out_sum, out_cout (= carry register) and out_overflow are held stable while out_ready=0.
  - On an edge with out_ready=1, the state returns to IDLE. No operand is accepted in the same cycle, so back-to-back throughput is one result per NIB+2 cycles.
  - out_sum holds its last value in IDLE and RUN and is only meaningful while out_valid=1.
- Overflow: out_overflow = (A[WIDTH-1] == B_eff[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]), using the original latched MSBs. The MSBs of A and B_eff are captured in 1-bit registers at accept.
- Arithmetic is modulo 2^WIDTH; the carry out of the top nibble only appears in out_cout.
- Boundary conditions:
  - in_valid asserted during RUN/DONE: ignored, no accept; the source must hold its data.
  - out_ready asserted outside DONE: no effect.
  - rst asserted mid-RUN or in DONE: the operation is aborted and no partial result is emitted.
  - The counter wraps only through the RUN->DONE transition, never beyond NIB-1.
  - WIDTH=4: one RUN cycle.

Decomposition:
- Shared package nibble_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t
  - localparam NIBBLE_W = 4
- Sub-module: the existing 4-bit ripple carry module `adder` (ports input1, input2, carry_in, sum, carry_out), instantiated once as the per-cycle datapath.
- Nibble counter width is $clog2(NIB), minimum 1.

Test Plan:
- WIDTH=16, add 0x1234+0x4321, cin=0, out_ready=1: out_valid exactly 4 cycles after accept, out_sum=0x5555, cout=0, overflow=0.
- Add 0xFFFF+0x0001, cin=0: out_sum=0x0000, cout=1, overflow=0. Add 0x7FFF+0x0000, cin=1: out_sum=0x8000, cout=0, overflow=1.
- Subtract 0x0005-0x0007: out_sum=0xFFFE, cout=0, overflow=0. Subtract 0x8000-0x0001: out_sum=0x7FFF, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE: outputs stable, in_ready=0, a new in_valid is not accepted. Release: IDLE next cycle, then the next bundle is accepted and its result is correct.
- Reset mid-operation: assert rst 2 cycles after accepting 0xAAAA+0x5555. Immediately out_valid=0 and out_sum=0; after release in_ready=1, and the following op 0x0F0F+0x0101 yields 0x1010 with no stale carry.
